// File: rtl/pulse_delay_multi_if.sv
// Bundle of the trigger, programming and pulse signals of pulse_delay_multi.
//   master : drives source_signal, delay_clks, width_clks, retrigger;
//            observes delay_signal, busy, dropped
//   slave  : the delay block itself (inverse directions)
interface pulse_delay_multi_if #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 8
);
    logic [CHANNELS-1:0]  source_signal;
    logic [CNT_WIDTH-1:0] delay_clks;
    logic [CNT_WIDTH-1:0] width_clks;
    logic                 retrigger;
    logic [CHANNELS-1:0]  delay_signal;
    logic [CHANNELS-1:0]  busy;
    logic [CHANNELS-1:0]  dropped;

    modport master (
        output source_signal, delay_clks, width_clks, retrigger,
        input  delay_signal, busy, dropped
    );

    modport slave (
        input  source_signal, delay_clks, width_clks, retrigger,
        output delay_signal, busy, dropped
    );
endinterface

// File: rtl/pulse_delay_multi.sv
// Multi-channel programmable pulse delay/stretcher.
// Each channel detects a rising edge on its source, waits max(D,1) clocks, then
// drives a pulse W clocks wide. D and W are latched at the trigger.
// Ports:
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset
//   bus : pulse_delay_multi_if.slave
//         in  source_signal[CHANNELS], delay_clks, width_clks, retrigger
//         out delay_signal[CHANNELS], busy[CHANNELS], dropped[CHANNELS] (registered)
module pulse_delay_multi #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    pulse_delay_multi_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StWait, StActive} state_e;

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    state_e               state_q [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] width_q [CHANNELS];
    logic [CHANNELS-1:0]  prev_q;
    logic [CHANNELS-1:0]  delay_q;
    logic [CHANNELS-1:0]  busy_q;
    logic [CHANNELS-1:0]  dropped_q;

    logic [CHANNELS-1:0]  trig;
    logic [CHANNELS-1:0]  accept;
    logic [CNT_WIDTH-1:0] deff;
    logic                 width_ok;

    assign deff     = (bus.delay_clks == '0) ? CntOne : bus.delay_clks;
    // A zero-width trigger is invisible: no state change and no drop report.
    assign width_ok = (bus.width_clks != '0);
    assign trig     = bus.source_signal & ~prev_q & {CHANNELS{width_ok}};

    // A channel whose pulse ends on this edge behaves as idle for a new trigger.
    always_comb begin
        accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = (state_q[i] == StIdle) ||
                        ((state_q[i] == StActive) && (cnt_q[i] == CntOne));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q    <= '0;
            delay_q   <= '0;
            busy_q    <= '0;
            dropped_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
                width_q[i] <= '0;
            end
        end else begin
            prev_q    <= bus.source_signal;
            dropped_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (trig[i] && accept[i]) begin
                    state_q[i] <= StWait;
                    cnt_q[i]   <= deff;
                    width_q[i] <= bus.width_clks;
                    busy_q[i]  <= 1'b1;
                    delay_q[i] <= 1'b0;
                end else if (trig[i] && bus.retrigger) begin
                    width_q[i] <= bus.width_clks;
                    if (state_q[i] == StWait) begin
                        cnt_q[i] <= deff;
                    end else begin
                        // Extend the pulse in flight; delay_signal stays high.
                        cnt_q[i] <= bus.width_clks;
                    end
                end else begin
                    if (trig[i]) begin
                        dropped_q[i] <= 1'b1;
                    end
                    case (state_q[i])
                        StWait: begin
                            if (cnt_q[i] == CntOne) begin
                                state_q[i] <= StActive;
                                cnt_q[i]   <= width_q[i];
                                delay_q[i] <= 1'b1;
                            end else begin
                                cnt_q[i] <= cnt_q[i] - CntOne;
                            end
                        end
                        StActive: begin
                            if (cnt_q[i] == CntOne) begin
                                state_q[i] <= StIdle;
                                delay_q[i] <= 1'b0;
                                busy_q[i]  <= 1'b0;
                            end else begin
                                cnt_q[i] <= cnt_q[i] - CntOne;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.delay_signal = delay_q;
    assign bus.busy         = busy_q;
    assign bus.dropped      = dropped_q;

endmodule

// File: tb/tb_pulse_delay_multi.sv
module tb_pulse_delay_multi;

    localparam int unsigned CHANNELS  = 4;
    localparam int unsigned CNT_WIDTH = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_delay_multi_if #(.CHANNELS(CHANNELS), .CNT_WIDTH(CNT_WIDTH)) bus ();

    pulse_delay_multi #(
        .CHANNELS  (CHANNELS),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Trigger channel ch at edge 0 (and at edge t2 if t2 >= 0), then compare every
    // edge against hand-computed rise/fall edges and drop edge.
    task automatic run_case(input string tag, input int ch, input int d, input int w,
                            input int d_after, input int t2, input bit retrig,
                            input int rise, input int fall, input int drop_e,
                            input int n_edges);
        logic [CHANNELS-1:0] one;
        one = '0;
        one[ch] = 1'b1;
        bus.delay_clks = CNT_WIDTH'(d);
        bus.width_clks = CNT_WIDTH'(w);
        bus.retrigger  = retrig;
        for (int e = 0; e < n_edges; e++) begin
            bus.source_signal = '0;
            if (e == 0 || e == t2) bus.source_signal[ch] = 1'b1;
            tick();
            if (e == 0) bus.delay_clks = CNT_WIDTH'(d_after);
            check_eq($sformatf("%s delay e%0d", tag, e), 32'(bus.delay_signal),
                     32'((e >= rise && e < fall) ? one : '0));
            check_eq($sformatf("%s busy e%0d", tag, e), 32'(bus.busy),
                     32'((e < fall) ? one : '0));
            check_eq($sformatf("%s dropped e%0d", tag, e), 32'(bus.dropped),
                     32'((e == drop_e) ? one : '0));
        end
        bus.source_signal = '0;
        tick();
    endtask

    initial begin
        bus.source_signal = '0;
        bus.delay_clks    = '0;
        bus.width_clks    = '0;
        bus.retrigger     = 1'b0;

        repeat (2) tick();
        check_eq("reset delay", 32'(bus.delay_signal), 32'h0);
        check_eq("reset busy", 32'(bus.busy), 32'h0);
        check_eq("reset dropped", 32'(bus.dropped), 32'h0);
        RST = 1'b0;
        tick();

        //        tag        ch  D    W   Dafter t2  rt rise fall drop n
        run_case("base",     0,  2,   1,  2,     -1, 0, 2,   3,   -1,  6);
        run_case("max",      1,  255, 255,255,   -1, 0, 255, 510, -1,  515);
        run_case("d0",       1,  0,   3,  0,     -1, 0, 1,   4,   -1,  7);
        run_case("drop",     2,  5,   4,  5,     3,  0, 5,   9,   3,   12);
        run_case("rt_wait",  2,  5,   4,  5,     3,  1, 8,   12,  -1,  15);
        run_case("rt_act",   3,  5,   4,  5,     6,  1, 5,   10,  -1,  13);
        run_case("latch",    3,  3,   2,  10,    -1, 0, 3,   5,   -1,  8);
        run_case("w0",       0,  2,   0,  2,     -1, 0, 0,   0,   -1,  6);

        // All channels at once, then reset while active.
        bus.delay_clks    = 8'd1;
        bus.width_clks    = 8'd4;
        bus.retrigger     = 1'b0;
        bus.source_signal = '1;
        tick();
        check_eq("all busy", 32'(bus.busy), 32'hf);
        bus.source_signal = '0;
        tick();
        check_eq("all delay", 32'(bus.delay_signal), 32'hf);
        RST = 1'b1;
        #1;
        check_eq("async rst delay", 32'(bus.delay_signal), 32'h0);
        check_eq("async rst busy", 32'(bus.busy), 32'h0);
        check_eq("async rst dropped", 32'(bus.dropped), 32'h0);
        bus.source_signal[0] = 1'b1;
        repeat (2) tick();
        check_eq("in rst delay", 32'(bus.delay_signal), 32'h0);
        RST = 1'b0;
        // Held-high source triggers once on the first edge after release.
        for (int e = 0; e < 10; e++) begin
            tick();
            check_eq($sformatf("held delay e%0d", e), 32'(bus.delay_signal),
                     (e >= 1 && e < 5) ? 32'h1 : 32'h0);
            check_eq($sformatf("held busy e%0d", e), 32'(bus.busy),
                     (e < 5) ? 32'h1 : 32'h0);
        end
        bus.source_signal = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_delay_multi.md
Name: pulse_delay_multi

Overview:
- Multi-channel programmable pulse delay/stretcher for the button-LED virtual interface.
- Each channel watches its source for a rising edge, waits a runtime-programmable number of clocks, then drives a pulse of programmable width.
- It adds a retrigger mode and a dropped-event indication, which the single-channel fixed delay lacked.
- It sits between the debounced button inputs and the LED/event outputs.

Parameters:
CHANNELS, 4, number of independent channels
CNT_WIDTH, 8, width of the delay and width counters and of the programming inputs

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  asynchronous, active-high reset
source_signal  input  CHANNELS  per-channel trigger inputs (synchronous to CLK)
delay_clks  input  CNT_WIDTH  delay D from edge detect to pulse start, shared by all channels
width_clks  input  CNT_WIDTH  pulse width W in clocks, shared by all channels
retrigger  input  1  0 = ignore triggers while busy; 1 = restart/extend on trigger
delay_signal  output  CHANNELS  delayed pulse outputs, registered
busy  output  CHANNELS  channel is in WAIT or ACTIVE, registered
dropped  output  CHANNELS  one-clock pulse when a trigger is ignored, registered

Behaviour:
- Reset (async, RST=1): every channel goes to IDLE. delay_signal, busy, dropped, the counters and the previous-sample register (prev) are all 0.
- Source held high across reset release is detected as an edge on the first clock after release.
- Edge detect, per channel: trigger at edge k when source_signal=1 and prev=0; prev<=source_signal every edge.
- Programming is latched at trigger: D and W are captured into the channel. Later changes to delay_clks/width_clks do not affect a pulse in flight.
- Effective delay is Deff = max(D,1).
- W = 0: the trigger is ignored entirely. The channel stays or continues as is; no dropped pulse is generated.
- Per-channel FSM:
  - IDLE: on trigger at edge k with W≠0 → WAIT; busy=1 from edge k; counter loaded.
  - WAIT: delay_signal=0. delay_signal rises at edge k+Deff, and the channel enters ACTIVE.
  - ACTIVE: delay_signal=1 for exactly W clocks, falling at edge k+Deff+W. The channel then goes to IDLE with busy=0 at that same edge.
  - ACTIVE → WAIT directly: if a new trigger arrives on the same edge the pulse ends, the channel is IDLE-equivalent and accepts it.
- Required timing with D=2, W=1: source sampled high at edge 0 gives delay_signal high after edge 2 and low after edge 3.
- Trigger while busy, retrigger=0: ignored; dropped=1 for exactly one clock (edge k to k+1); the pulse in flight is unaffected.
- Trigger while busy, retrigger=1:
  - In WAIT: the delay restarts from the new edge, with D and W relatched.
  - In ACTIVE: the remaining width is reloaded to the new W (relatched); delay_signal stays high with no glitch, so the pulse is extended.
  - dropped stays 0 in both cases.
- retrigger is sampled at the trigger edge only.
- Channels are fully independent. Simultaneous triggers on all channels are each handled per the rules above.
- Counters are CNT_WIDTH bits and never wrap: D=W=2^CNT_WIDTH−1 gives the full-length delay and width.
- RST asserted mid-pulse clears delay_signal and busy immediately (asynchronously), with no residual pulse after release.

Test Plan:
- Base delay: D=2, W=1, 1-clock source pulse on ch0 at edge 0 → delay_signal[0]=1 after edge 2, 0 after edge 3; busy[0] high edges 0..3; other channels 0.
- Width/max: D=255, W=255 on ch1 → rise exactly 255 clocks after trigger, high exactly 255 clocks, no wrap; D=0,W=3 → rise 1 clock after trigger.
- Drop: retrigger=0, D=5, W=4, ch2 triggers at edge 0 and edge 3 → single pulse at edges 5..9; dropped[2]=1 for one clock after edge 3 only.
- Retrigger: retrigger=1, D=5, W=4, triggers at edge 0 and edge 3 → pulse edges 8..12. Variant: second trigger at edge 6 (ACTIVE) → pulse edges 5..10, no gap.
- Latch/W=0: change delay_clks from 3 to 10 one clock after trigger → rise still at edge 3; trigger with W=0 → no pulse, busy stays 0, dropped 0.
- Reset mid-op: assert RST during ACTIVE on all channels → all outputs 0 immediately. Hold source_signal[0]=1 through release → ch0 triggers at first post-release edge; held-high sources do not retrigger.
